// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding and saturation limits for the fruit scheduler.
package snake_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN = 3'd1;
  localparam logic [2:0] ST_HIDDEN = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_OVER = 3'd4;
  localparam logic [3:0] LEVEL_MAX = 4'd15;
  localparam logic [7:0] EAT_MAX = 8'd255;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RUN = ST_RUN,
    S_HIDDEN = ST_HIDDEN,
    S_PAUSED = ST_PAUSED,
    S_OVER = ST_OVER
  } state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts enabled clocks and pulses wrap on the last clock of each period.
module tick_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             wrap
);
  logic [DIV_W-1:0] cnt;
  // >= keeps the count bounded even if the period shrinks under a running count
  assign wrap = enable && (cnt >= period - 1'b1);
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (wrap) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fruit_move_scheduler.sv
// fruit_move_scheduler: level-paced move_fruit strobe, post-eat hiding, eat/level tracking.
// Define FRUIT_SPEEDUP_EN to shorten the move period as the level rises.
module fruit_move_scheduler
  import snake_pkg::*;
#(
  parameter int DIV_W          = 24,
  parameter int BASE_DIV       = 2_500_000,
  parameter int MIN_DIV        = 500_000,
  parameter int STEP_DIV       = 250_000,
  parameter int EATS_PER_LEVEL = 4,
  parameter int RESPAWN_TICKS  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       fruit_eaten,
  output logic       move_fruit,
  output logic       fruit_visible,
  output logic [3:0] level,
  output logic [7:0] eat_count,
  output logic [2:0] state
);
`ifdef FRUIT_SPEEDUP_EN
  localparam logic SPEEDUP = 1'b1;
`else
  localparam logic SPEEDUP = 1'b0;
`endif
  localparam int PW = DIV_W + 4;
  localparam logic [PW-1:0] BASE_P = PW'(BASE_DIV);
  localparam logic [PW-1:0] MIN_P = PW'(MIN_DIV);
  localparam logic [PW-1:0] STEP_P = PW'(STEP_DIV);
  state_t st;
  logic saved_hidden;
  logic [7:0] level_eats, hide_cnt;
  logic [PW-1:0] red, raw;
  logic [DIV_W-1:0] period;
  logic advance, eat, wrap;
  // widened arithmetic so a large level*step never wraps below the floor
  assign red = SPEEDUP ? PW'(level) * STEP_P : '0;
  assign raw = (red >= BASE_P) ? '0 : BASE_P - red;
  assign period = DIV_W'((raw < MIN_P) ? MIN_P : raw);
  assign advance = (st == S_RUN || st == S_HIDDEN) && !game_over && !pause;
  assign eat = advance && st == S_RUN && fruit_eaten;
  assign state = st;
  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clock (clock),
    .reset (reset),
    .enable(advance),
    .clear (eat || st == S_IDLE),
    .period(period),
    .wrap  (wrap)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= S_IDLE;
      move_fruit <= 1'b0;
      fruit_visible <= 1'b0;
      level <= '0;
      eat_count <= '0;
      level_eats <= '0;
      hide_cnt <= '0;
      saved_hidden <= 1'b0;
    end else begin
      move_fruit <= 1'b0;
      if (game_over && st != S_IDLE) begin
        st <= S_OVER;
        fruit_visible <= 1'b0;
      end else begin
        case (st)
          S_IDLE: if (start) begin
            st <= S_RUN;
            fruit_visible <= 1'b1;
          end
          S_RUN, S_HIDDEN: if (pause) begin
            st <= S_PAUSED;
            saved_hidden <= st == S_HIDDEN;
          end else if (eat) begin
            eat_count <= (eat_count == EAT_MAX) ? eat_count : eat_count + 1'b1;
            level_eats <= (level_eats == 8'(EATS_PER_LEVEL - 1)) ? '0 : level_eats + 1'b1;
            if (level_eats == 8'(EATS_PER_LEVEL - 1) && level != LEVEL_MAX) level <= level + 1'b1;
            st <= S_HIDDEN;
            fruit_visible <= 1'b0;
            hide_cnt <= '0;
          end else if (wrap) begin
            if (st == S_RUN) move_fruit <= 1'b1;
            else if (hide_cnt == 8'(RESPAWN_TICKS - 1)) begin
              st <= S_RUN;
              fruit_visible <= 1'b1;
              hide_cnt <= '0;
            end else hide_cnt <= hide_cnt + 1'b1;
          end
          S_PAUSED: if (!pause) st <= saved_hidden ? S_HIDDEN : S_RUN;
          S_OVER: st <= S_OVER;
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fruit_move_scheduler.sv
// tb_fruit_move_scheduler: vector table for state transitions plus a strobe-time scoreboard.
module tb_fruit_move_scheduler;
  import snake_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1, start = 1'b0, pause = 1'b0, game_over = 1'b0, fruit_eaten = 1'b0;
  logic move_fruit, fruit_visible;
  logic [3:0] level;
  logic [7:0] eat_count;
  logic [2:0] state;
  int cyc = 0, checks = 0, errors = 0, e_cyc;
  int exp_q[$];
  int m_lvl, m_eats, m_le;
  fruit_move_scheduler #(
    .BASE_DIV(20), .MIN_DIV(8), .STEP_DIV(4), .EATS_PER_LEVEL(2), .RESPAWN_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .game_over(game_over),
    .fruit_eaten(fruit_eaten), .move_fruit(move_fruit), .fruit_visible(fruit_visible),
    .level(level), .eat_count(eat_count), .state(state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {
    logic st, pa, go, fe;
    logic [2:0] e_state;
    logic e_vis;
    int e_cnt;
  } vec_t;
  vec_t tbl[13];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // every strobe must match the next expected cycle in the scoreboard
  always @(negedge clock) if (move_fruit === 1'b1) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected strobe: got strobe at cycle %0d expected none", cyc);
    end else begin
      e_cyc = exp_q.pop_front();
      check("strobe cycle", cyc, e_cyc);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  function automatic int period_of(input int lvl);
`ifdef FRUIT_SPEEDUP_EN
    return (20 - lvl * 4) < 8 ? 8 : 20 - lvl * 4;
`else
    return 20;
`endif
  endfunction
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; fruit_eaten = 1'b0;
    tick(2);
    check("reset state", state, ST_IDLE);
    check("reset visible", fruit_visible, 0);
    check("reset move", move_fruit, 0);
    check("reset level", level, 0);
    check("reset eat_count", eat_count, 0);
    reset = 1'b0;
    m_lvl = 0; m_eats = 0; m_le = 0;
  endtask
  task automatic model_eat();
    m_eats = m_eats < 255 ? m_eats + 1 : 255;
    m_le++;
    if (m_le == 2) begin
      m_le = 0;
      if (m_lvl < 15) m_lvl++;
    end
  endtask
  // eat now, sit out three hidden periods, then expect n strobes one period apart
  task automatic do_eat(input bit full, input int n);
    int p, c;
    c = cyc;
    fruit_eaten = 1'b1;
    tick(1);
    fruit_eaten = 1'b0;
    model_eat();
    p = period_of(m_lvl);
    if (full) begin
      check("eat state hidden", state, ST_HIDDEN);
      check("eat visible off", fruit_visible, 0);
    end
    tick(3 * p - 1);
    if (full) check("still hidden", state, ST_HIDDEN);
    tick(1);
    if (full) begin
      check("respawn state", state, ST_RUN);
      check("respawn visible", fruit_visible, 1);
      check("eat_count", eat_count, m_eats);
      check("level", level, m_lvl);
    end
    for (int k = 1; k <= n; k++) exp_q.push_back(c + 1 + (3 + k) * p);
    tick(n * p);
  endtask
  initial begin
    int c, p;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,   1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,   1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN,    1'b1, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_PAUSED, 1'b1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, ST_PAUSED, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_RUN,    1'b1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_HIDDEN, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_HIDDEN, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_PAUSED, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HIDDEN, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_OVER,   1'b0, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_OVER,   1'b0, 1};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; pause = tbl[i].pa; game_over = tbl[i].go; fruit_eaten = tbl[i].fe;
      tick(1);
      check($sformatf("vec%0d state", i), state, tbl[i].e_state);
      check($sformatf("vec%0d visible", i), fruit_visible, tbl[i].e_vis);
      check($sformatf("vec%0d eat_count", i), eat_count, tbl[i].e_cnt);
    end
    // start, then three base-period strobes
    do_reset();
    c = cyc;
    start = 1'b1;
    tick(1);
    check("start state", state, ST_RUN);
    check("start visible", fruit_visible, 1);
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 1 + 20 * k);
    tick(60);
    // four eats: level advances every two
    for (int i = 0; i < 4; i++) do_eat(1'b1, 2);
    check("four eats count", eat_count, 4);
    check("four eats level", level, 2);
    // eat lands on the wrap edge: no strobe there
    p = period_of(m_lvl);
    tick(p - 1);
    do_eat(1'b1, 1);
    // pause mid-period for 50 clocks
    c = cyc;
    p = period_of(m_lvl);
    tick(5);
    pause = 1'b1;
    tick(1);
    check("paused state", state, ST_PAUSED);
    tick(49);
    check("paused visible", fruit_visible, 1);
    pause = 1'b0;
    exp_q.push_back(c + p + 51);
    tick(1);
    check("unpaused state", state, ST_RUN);
    tick(p - 5);
    // game over while hidden
    fruit_eaten = 1'b1;
    tick(1);
    fruit_eaten = 1'b0;
    model_eat();
    tick(3);
    check("hidden before over", state, ST_HIDDEN);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check("over state", state, ST_OVER);
    check("over visible", fruit_visible, 0);
    tick(200);
    check("over holds", state, ST_OVER);
    check("over eat_count", eat_count, m_eats);
    // saturation of level and eat_count
    do_reset();
    start = 1'b1;
    tick(1);
    for (int i = 0; i < 260; i++) do_eat(1'b0, 0);
    check("sat level", level, 15);
    check("sat eat_count", eat_count, 255);
    check("sat state", state, ST_RUN);
    c = cyc;
    p = period_of(15);
    exp_q.push_back(c + p);
    exp_q.push_back(c + 2 * p);
    tick(2 * p + 2);
    check("strobe queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
